// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register.
// Captures the decoded control bundle, operands and register specifiers once
// per cycle, with stall (hold), flush (bubble) and illegal-opcode squash.
// A bubble always carries all-zero control and data, so it cannot write a
// register, write memory or branch. IllegalE is a sticky flag, and
// BubbleCntE is a saturating count of the bubbles loaded, kept for perf debug.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              ValidD,
   input  logic              IllegalOpD,
   input  logic              RegWriteD,
   input  logic              RegDstD,
   input  logic              ALUSrcD,
   input  logic              BranchD,
   input  logic              MemWriteD,
   input  logic              MemtoRegD,
   input  logic [1:0]        ALUOpD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [DATA_W-1:0] SignImmD,
   input  logic [REG_W-1:0]  RsD,
   input  logic [REG_W-1:0]  RtD,
   input  logic [REG_W-1:0]  RdD,
   output logic              ValidE,
   output logic              RegWriteE,
   output logic              RegDstE,
   output logic              ALUSrcE,
   output logic              BranchE,
   output logic              MemWriteE,
   output logic              MemtoRegE,
   output logic [1:0]        ALUOpE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] SignImmE,
   output logic [REG_W-1:0]  RsE,
   output logic [REG_W-1:0]  RtE,
   output logic [REG_W-1:0]  RdE,
   output logic              IllegalE,
   output logic [CNT_W-1:0]  BubbleCntE
);

   logic              valid_q,      valid_d;
   logic              reg_write_q,  reg_write_d;
   logic              reg_dst_q,    reg_dst_d;
   logic              alu_src_q,    alu_src_d;
   logic              branch_q,     branch_d;
   logic              mem_write_q,  mem_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic [1:0]        alu_op_q,     alu_op_d;
   logic [DATA_W-1:0] rd1_q,        rd1_d;
   logic [DATA_W-1:0] rd2_q,        rd2_d;
   logic [DATA_W-1:0] sign_imm_q,   sign_imm_d;
   logic [REG_W-1:0]  rs_q,         rs_d;
   logic [REG_W-1:0]  rt_q,         rt_d;
   logic [REG_W-1:0]  rd_q,         rd_d;
   logic              illegal_q,    illegal_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic load_ok;
   logic take_bubble;
   logic cnt_full;

   // Decide this cycle's action: flush beats stall, stall beats load, and a
   // load of anything other than a valid legal instruction becomes a bubble.
   always_comb begin
      load_ok     = ValidD & ~IllegalOpD;
      take_bubble = FlushE | (~StallE & ~load_ok);
      cnt_full    = (bubble_cnt_q == {CNT_W{1'b1}});
   end

   // Next-state for every E-stage field; hold is the default.
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      reg_dst_d    = reg_dst_q;
      alu_src_d    = alu_src_q;
      branch_d     = branch_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      alu_op_d     = alu_op_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      sign_imm_d   = sign_imm_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      rd_d         = rd_q;
      illegal_d    = illegal_q;
      bubble_cnt_d = bubble_cnt_q;

      if (take_bubble) begin
         // Zero everything so no decoder output, possibly X, reaches E.
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         reg_dst_d    = 1'b0;
         alu_src_d    = 1'b0;
         branch_d     = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         alu_op_d     = 2'b00;
         rd1_d        = '0;
         rd2_d        = '0;
         sign_imm_d   = '0;
         rs_d         = '0;
         rt_d         = '0;
         rd_d         = '0;
         if (!cnt_full) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
         end
         // Only a squash on a real load sets the sticky flag, never a flush.
         if (!FlushE && ValidD && IllegalOpD) begin
            illegal_d = 1'b1;
         end
      end else if (!StallE) begin
         valid_d      = 1'b1;
         reg_write_d  = RegWriteD;
         reg_dst_d    = RegDstD;
         alu_src_d    = ALUSrcD;
         branch_d     = BranchD;
         mem_write_d  = MemWriteD;
         mem_to_reg_d = MemtoRegD;
         alu_op_d     = ALUOpD;
         rd1_d        = RD1D;
         rd2_d        = RD2D;
         sign_imm_d   = SignImmD;
         rs_d         = RsD;
         rt_d         = RtD;
         rd_d         = RdD;
      end
   end

   // E-stage state; async reset clears everything, including during a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         reg_dst_q    <= 1'b0;
         alu_src_q    <= 1'b0;
         branch_q     <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_op_q     <= 2'b00;
         rd1_q        <= '0;
         rd2_q        <= '0;
         sign_imm_q   <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         illegal_q    <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         reg_dst_q    <= reg_dst_d;
         alu_src_q    <= alu_src_d;
         branch_q     <= branch_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_op_q     <= alu_op_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         sign_imm_q   <= sign_imm_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         illegal_q    <= illegal_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Outputs come straight from flops: no input-to-output combinational path.
   always_comb begin
      ValidE     = valid_q;
      RegWriteE  = reg_write_q;
      RegDstE    = reg_dst_q;
      ALUSrcE    = alu_src_q;
      BranchE    = branch_q;
      MemWriteE  = mem_write_q;
      MemtoRegE  = mem_to_reg_q;
      ALUOpE     = alu_op_q;
      RD1E       = rd1_q;
      RD2E       = rd2_q;
      SignImmE   = sign_imm_q;
      RsE        = rs_q;
      RtE        = rt_q;
      RdE        = rd_q;
      IllegalE   = illegal_q;
      BubbleCntE = bubble_cnt_q;
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vectors, an abstract model of what
// E must hold, a per-cycle compare process and a few literal pins.
module tb_id_ex_pipe_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        StallE = 1'b0, FlushE = 1'b0, ValidD = 1'b0, IllegalOpD = 1'b0;
   logic        RegWriteD = 1'b0, RegDstD = 1'b0, ALUSrcD = 1'b0, BranchD = 1'b0;
   logic        MemWriteD = 1'b0, MemtoRegD = 1'b0;
   logic [1:0]  ALUOpD = 2'b00;
   logic [31:0] RD1D = '0, RD2D = '0, SignImmD = '0;
   logic [4:0]  RsD = '0, RtD = '0, RdD = '0;

   logic        ValidE, RegWriteE, RegDstE, ALUSrcE, BranchE, MemWriteE, MemtoRegE;
   logic [1:0]  ALUOpE;
   logic [31:0] RD1E, RD2E, SignImmE;
   logic [4:0]  RsE, RtE, RdE;
   logic        IllegalE;
   logic [15:0] BubbleCntE;

   // Second instance with a 4-bit counter, same stimulus, to see saturation.
   logic        s_valid, s_rw, s_rdst, s_as, s_br, s_mw, s_m2r, s_ill;
   logic [1:0]  s_aluop;
   logic [31:0] s_rd1, s_rd2, s_imm;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [3:0]  s_cnt;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
      .ValidD(ValidD), .IllegalOpD(IllegalOpD),
      .RegWriteD(RegWriteD), .RegDstD(RegDstD), .ALUSrcD(ALUSrcD),
      .BranchD(BranchD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
      .ALUOpD(ALUOpD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .ValidE(ValidE), .RegWriteE(RegWriteE), .RegDstE(RegDstE),
      .ALUSrcE(ALUSrcE), .BranchE(BranchE), .MemWriteE(MemWriteE),
      .MemtoRegE(MemtoRegE), .ALUOpE(ALUOpE), .RD1E(RD1E), .RD2E(RD2E),
      .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .IllegalE(IllegalE), .BubbleCntE(BubbleCntE)
   );

   id_ex_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
      .ValidD(ValidD), .IllegalOpD(IllegalOpD),
      .RegWriteD(RegWriteD), .RegDstD(RegDstD), .ALUSrcD(ALUSrcD),
      .BranchD(BranchD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
      .ALUOpD(ALUOpD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .ValidE(s_valid), .RegWriteE(s_rw), .RegDstE(s_rdst),
      .ALUSrcE(s_as), .BranchE(s_br), .MemWriteE(s_mw),
      .MemtoRegE(s_m2r), .ALUOpE(s_aluop), .RD1E(s_rd1), .RD2E(s_rd2),
      .SignImmE(s_imm), .RsE(s_rs), .RtE(s_rt), .RdE(s_rd),
      .IllegalE(s_ill), .BubbleCntE(s_cnt)
   );

   // ---------------- model ----------------
   // E contents as one bundle: what a real instruction brings, or zero.
   logic [119:0] m_e = '0;
   bit           m_ill = 1'b0;
   int           m_bubbles = 0;

   wire [119:0] d_bundle = {1'b1, RegWriteD, RegDstD, ALUSrcD, BranchD, MemWriteD,
                            MemtoRegD, ALUOpD, RD1D, RD2D, SignImmD, RsD, RtD, RdD};
   wire [119:0] e_bundle = {ValidE, RegWriteE, RegDstE, ALUSrcE, BranchE, MemWriteE,
                            MemtoRegE, ALUOpE, RD1E, RD2E, SignImmE, RsE, RtE, RdE};
   wire [119:0] s_bundle = {s_valid, s_rw, s_rdst, s_as, s_br, s_mw,
                            s_m2r, s_aluop, s_rd1, s_rd2, s_imm, s_rs, s_rt, s_rd};

   // A stalled cycle changes nothing; otherwise E gets the instruction if it
   // is real and legal and not flushed, else an empty slot that is counted.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_e       <= '0;
         m_ill     <= 1'b0;
         m_bubbles <= 0;
      end else if (FlushE || !StallE) begin
         if (!FlushE && ValidD && !IllegalOpD) begin
            m_e <= d_bundle;
         end else begin
            m_e       <= '0;
            m_bubbles <= m_bubbles + 1;
            if (!FlushE && ValidD && IllegalOpD) m_ill <= 1'b1;
         end
      end
   end

   function automatic logic [15:0] exp_cnt16();
      return (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
   endfunction

   function automatic logic [3:0] exp_cnt4();
      return (m_bubbles > 15) ? 4'hF : 4'(m_bubbles);
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (e_bundle !== m_e || IllegalE !== m_ill || BubbleCntE !== exp_cnt16()) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got e=%h ill=%b cnt=%0d want e=%h ill=%b cnt=%0d",
                     $time, e_bundle, IllegalE, BubbleCntE, m_e, m_ill, exp_cnt16());
         end
         n_cmp++;
         if (s_bundle !== m_e || s_ill !== m_ill || s_cnt !== exp_cnt4()) begin
            n_fail++;
            $display("FAIL small_cmp t=%0t got e=%h ill=%b cnt=%0d want e=%h ill=%b cnt=%0d",
                     $time, s_bundle, s_ill, s_cnt, m_e, m_ill, exp_cnt4());
         end
         n_cmp++;
         if (ValidE !== 1'b1 && {RegWriteE, MemWriteE, BranchE} !== 3'b000) begin
            n_fail++;
            $display("FAIL bubble_inv t=%0t got rw/mw/br=%b%b%b with ValidE=%b want 000",
                     $time, RegWriteE, MemWriteE, BranchE, ValidE);
         end
      end
   end

   // ---------------- driver ----------------
   // ctrl = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0]}
   task automatic drive(input logic st, input logic fl, input logic vd, input logic il,
                        input logic [7:0] ctrl, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      @(negedge clk);
      StallE = st; FlushE = fl; ValidD = vd; IllegalOpD = il;
      {RegWriteD, RegDstD, ALUSrcD, BranchD, MemWriteD, MemtoRegD, ALUOpD} = ctrl;
      RD1D = r1; RD2D = r2; SignImmD = imm; RsD = rs; RtD = rt; RdD = rd;
      if (st && fl) $display("warning: StallE and FlushE both asserted at t=%0t", $time);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   localparam logic [7:0] LW_CTRL = 8'b1010_0100;  // RegWrite, ALUSrc, MemtoReg, ALUOp=00
   localparam logic [7:0] R_CTRL  = 8'b1100_0010;  // RegWrite, RegDst, ALUOp=10
   localparam logic [7:0] SW_CTRL = 8'b0010_1000;  // ALUSrc, MemWrite

   logic [15:0] cnt_before;

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      #1;
      pin("reset_state", {ValidE, RegWriteE, RD1E, IllegalE, BubbleCntE}, '0);

      // LW load: one cycle D->E.
      drive(0, 0, 1, 0, LW_CTRL, 32'h1234, 32'h55, 32'h8, 5'd1, 5'd2, 5'd0);
      after_edge();
      pin("lw_regwrite", RegWriteE, 1);
      pin("lw_rd1", RD1E, 32'h1234);
      pin("lw_valid", ValidE, 1);

      // Stall three cycles while D changes; then release.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, R_CTRL, 32'hA000 + i, 32'hB000 + i, 32'h0, 5'd3, 5'd4, 5'd5);
      end
      after_edge();
      pin("stall_hold_rd1", RD1E, 32'h1234);
      pin("stall_hold_memtoreg", MemtoRegE, 1);
      drive(0, 0, 1, 0, SW_CTRL, 32'hCAFE, 32'hBEEF, 32'h10, 5'd6, 5'd7, 5'd8);
      after_edge();
      pin("unstall_rd1", RD1E, 32'hCAFE);
      pin("unstall_memwrite", MemWriteE, 1);

      // Flush and stall together with an R-type at D: flush wins.
      cnt_before = BubbleCntE;
      drive(1, 1, 1, 0, R_CTRL, 32'h1, 32'h2, 32'h3, 5'd9, 5'd10, 5'd11);
      after_edge();
      pin("flush_valid", ValidE, 0);
      pin("flush_regwrite", RegWriteE, 0);
      pin("flush_cnt", BubbleCntE, cnt_before + 16'd1);

      // Illegal opcode squash with X controls, then ten legal loads.
      @(negedge clk);
      StallE = 0; FlushE = 0; ValidD = 1; IllegalOpD = 1;
      {RegWriteD, RegDstD, ALUSrcD, BranchD, MemWriteD, MemtoRegD, ALUOpD} = 'x;
      RD1D = 'x; RD2D = 'x; SignImmD = 'x; RsD = 'x; RtD = 'x; RdD = 'x;
      after_edge();
      pin("illegal_valid", ValidE, 0);
      pin("illegal_flag", IllegalE, 1);
      pin("illegal_no_x", 64'($isunknown({e_bundle, IllegalE, BubbleCntE})), 0);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 0, (i % 2) ? R_CTRL : LW_CTRL, 32'h100 * i, 32'h7 + i,
               32'hFFFF_FFF0 + i, 5'(i), 5'(i + 1), 5'(i + 2));
      end
      after_edge();
      pin("illegal_sticky", IllegalE, 1);
      pin("load_after_illegal_rd1", RD1E, 32'h900);

      // Illegal under stall or flush does not set the flag (fresh reset first).
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      pin("async_reset_valid", ValidE, 0);
      pin("async_reset_all", {e_bundle, IllegalE, BubbleCntE, s_cnt}, '0);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 0, 1, 1, R_CTRL, 32'h5, 32'h6, 32'h7, 5'd1, 5'd1, 5'd1);
      drive(0, 1, 1, 1, R_CTRL, 32'h5, 32'h6, 32'h7, 5'd1, 5'd1, 5'd1);
      after_edge();
      pin("illegal_under_flush", IllegalE, 0);

      // Reset mid-stall with nonzero outputs, before the next edge.
      drive(0, 0, 1, 0, R_CTRL, 32'hDEAD, 32'h1, 32'h2, 5'd3, 5'd4, 5'd5);
      drive(1, 0, 1, 0, LW_CTRL, 32'h9, 32'h9, 32'h9, 5'd9, 5'd9, 5'd9);
      after_edge();
      pin("pre_reset_rd1", RD1E, 32'hDEAD);
      #2 reset = 1'b1;
      #1;
      pin("midstall_reset", {e_bundle, IllegalE, BubbleCntE}, '0);
      @(negedge clk);
      reset = 1'b0;
      StallE = 0;

      // Twenty consecutive bubbles: the 4-bit counter saturates at 15.
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, R_CTRL, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
      end
      after_edge();
      pin("sat_cnt4", s_cnt, 4'hF);
      pin("cnt16_twenty", BubbleCntE, 16'd20);

      // A few random legal loads mixed with stalls and flushes.
      for (int i = 0; i < 40; i++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               8'($urandom_range(0, 255)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));
      end
      after_edge();
      @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
